multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the MIPS integer datapath.
- Steps each instruction through FETCH, DECODE, EXEC and WB, one shared ALU/regfile pass per instruction.
- Handshakes with instruction memory and decodes opcode/funct into ALU and regfile controls.
- Traps on illegal opcodes and fetch timeouts; sits between the IR register and the ALU/regfile.

---
 rtl/multicycle_ctrl.sv | 112 +++++++++++
 tb/tb_multicycle_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/WB sequencer for a multi-cycle MIPS integer datapath
// Ports: clk, reset_n (async, active-low); run/clear control; opcode/funct from the IR;
// imem_req/imem_ready fetch handshake; ir_write, pc_write, alu_src_b, reg_dst, reg_write,
// alu_op datapath controls; busy/done/trap/err_code status; retired instruction count.
// alu_op encoding: 0 NOP, 1 ADD, 2 ADDU, 3 SUB, 4 SUBU, 5 AND, 6 OR, 7 XOR, 8 SLL, 9 SRL, 10 SRA.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clear,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_src_b,
  output logic             reg_dst,
  output logic             reg_write,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             trap,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, ADDU = 4'd2, SUB = 4'd3, SUBU = 4'd4,
                         AND = 4'd5, OR = 4'd6, XOR = 4'd7, SLL = 4'd8, SRL = 4'd9, SRA = 4'd10;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, TRAP} state_t;
  state_t state, nxt;
  logic [TW-1:0] cnt;
  logic [3:0] d_op, dec_op;
  logic d_imm, d_ok, dec_imm, halt, exe;
  always_comb begin
    d_op = NOP;
    d_imm = 1'b0;
    d_ok = 1'b1;
    case (opcode)
      6'h00:
        case (funct)
          6'h20: d_op = ADD;
          6'h21: d_op = ADDU;
          6'h22: d_op = SUB;
          6'h23: d_op = SUBU;
          6'h24: d_op = AND;
          6'h25: d_op = OR;
          6'h26: d_op = XOR;
          6'h00: d_op = SLL;
          6'h02: d_op = SRL;
          6'h03: d_op = SRA;
          default: d_ok = 1'b0;
        endcase
      6'h08: begin d_op = ADD; d_imm = 1'b1; end
      6'h09: begin d_op = ADDU; d_imm = 1'b1; end
      6'h0C: begin d_op = AND; d_imm = 1'b1; end
      6'h0D: begin d_op = OR; d_imm = 1'b1; end
      6'h0E: begin d_op = XOR; d_imm = 1'b1; end
      default: d_ok = 1'b0;
    endcase
  end
  assign halt = opcode == 6'h3F;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = imem_ready ? DECODE : (cnt == TW'(TIMEOUT - 1)) ? TRAP : FETCH;
      DECODE:  nxt = halt ? IDLE : d_ok ? EXEC : TRAP;
      EXEC:    nxt = WB;
      WB:      nxt = run ? FETCH : IDLE;
      TRAP:    nxt = clear ? IDLE : TRAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      dec_op <= NOP;
      dec_imm <= 1'b0;
      err_code <= 2'd0;
      retired <= '0;
    end else begin
      state <= nxt;
      // counter is zero on every entry into FETCH and counts waited cycles there
      cnt <= (state == FETCH) ? cnt + TW'(1) : '0;
      if (state == DECODE) begin
        dec_op <= d_op;
        dec_imm <= d_imm;
      end
      if (state == FETCH && nxt == TRAP) err_code <= 2'd1;
      else if (state == DECODE && nxt == TRAP) err_code <= 2'd2;
      else if (state == TRAP && clear) err_code <= 2'd0;
      if (state == WB) retired <= retired + CNT_W'(1);
    end
  end
  // decoded controls are only presented to the datapath during EXEC and WB
  assign exe = state == EXEC || state == WB;
  assign alu_op = exe ? dec_op : NOP;
  assign alu_src_b = exe & dec_imm;
  assign reg_dst = exe & ~dec_imm;
  assign imem_req = state == FETCH;
  assign ir_write = imem_req & imem_ready;
  assign pc_write = imem_req & imem_ready;
  assign reg_write = state == WB;
  assign busy = state != IDLE && state != TRAP;
  assign done = state == DECODE && halt;
  assign trap = state == TRAP;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction-level check of multicycle_ctrl against a reference trace
module tb_multicycle_ctrl;
  localparam int TO = 16, CW = 4;
  localparam logic [3:0] NOP = 4'd0;
  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, clear = 1'b0, imem_ready = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic imem_req, ir_write, pc_write, alu_src_b, reg_dst, reg_write, busy, done, trap;
  logic [3:0] alu_op;
  logic [1:0] err_code;
  logic [CW-1:0] retired;
  logic n_run = 1'b0, n_clr = 1'b0, n_rdy = 1'b0;
  logic [5:0] n_op = 6'd0, n_fn = 6'd0;
  logic [CW-1:0] ret = '0;
  bit idle = 1'b1;
  int n_chk = 0, n_pass = 0;
  logic [5:0] r_fn [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03};
  logic [3:0] r_op [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  logic [5:0] i_oc [5] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
  logic [3:0] i_op [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7};

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .reg_write(reg_write), .alu_op(alu_op),
    .busy(busy), .done(done), .trap(trap), .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic expect_out(input logic req, input logic irw, input logic rw, input logic [3:0] aop,
                            input logic srcb, input logic dst, input logic bsy, input logic dn,
                            input logic trp, input logic [1:0] err);
    chk("imem_req", 32'(imem_req), 32'(req));
    chk("ir_write", 32'(ir_write), 32'(irw));
    chk("pc_write", 32'(pc_write), 32'(irw));
    chk("reg_write", 32'(reg_write), 32'(rw));
    chk("alu_op", 32'(alu_op), 32'(aop));
    chk("alu_src_b", 32'(alu_src_b), 32'(srcb));
    chk("reg_dst", 32'(reg_dst), 32'(dst));
    chk("busy", 32'(busy), 32'(bsy));
    chk("done", 32'(done), 32'(dn));
    chk("trap", 32'(trap), 32'(trp));
    chk("err_code", 32'(err_code), 32'(err));
    chk("retired", 32'(retired), 32'(ret));
  endtask

  task automatic cyc();
    @(negedge clk);
    run = n_run;
    clear = n_clr;
    imem_ready = n_rdy;
    opcode = n_op;
    funct = n_fn;
    #1;
  endtask

  task automatic noise();
    n_op = 6'($urandom);
    n_fn = 6'($urandom);
    n_rdy = 1'($urandom);
    n_run = 1'($urandom);
    n_clr = 1'($urandom);
  endtask

  // kind: 0 register ALU op, 1 immediate ALU op, 2 halt, 3 illegal
  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn, output int kind,
                                  output logic [3:0] aop);
    kind = (op == 6'h3F) ? 2 : 3;
    aop = NOP;
    for (int i = 0; i < 10; i++)
      if (op == 6'h00 && fn == r_fn[i]) begin kind = 0; aop = r_op[i]; end
    for (int i = 0; i < 5; i++)
      if (op == i_oc[i]) begin kind = 1; aop = i_op[i]; end
  endfunction

  task automatic trap_seq(input logic [1:0] e);
    int k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      noise();
      n_clr = 1'b0;
      cyc();
      expect_out(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    end
    noise();
    n_clr = 1'b1;
    cyc();
    expect_out(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    idle = 1'b1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int stall,
                       input logic keep, input bit rst_exec);
    int kind;
    logic [3:0] aop;
    logic rdy;
    ref_dec(op, fn, kind, aop);
    if (idle) begin
      noise();
      n_run = 1'b1;
      cyc();
      expect_out(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    for (int i = 0; i <= stall && i < TO; i++) begin
      rdy = (i == stall);
      noise();
      n_rdy = rdy;
      cyc();
      expect_out(1'b1, rdy, 1'b0, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    if (stall >= TO) begin trap_seq(2'd1); return; end
    noise();
    n_op = op;
    n_fn = fn;
    cyc();
    expect_out(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b1, kind == 2, 1'b0, 2'd0);
    if (kind == 2) begin idle = 1'b1; return; end
    if (kind == 3) begin trap_seq(2'd2); return; end
    noise();
    cyc();
    expect_out(1'b0, 1'b0, 1'b0, aop, kind == 1, kind == 0, 1'b1, 1'b0, 1'b0, 2'd0);
    if (rst_exec) begin
      reset_n = 1'b0;
      run = 1'b0;
      n_run = 1'b0;
      ret = '0;
      idle = 1'b1;
      #1;
      expect_out(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      @(posedge clk);
      #1;
      expect_out(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      reset_n = 1'b1;
      return;
    end
    noise();
    n_run = keep;
    cyc();
    expect_out(1'b0, 1'b0, 1'b1, aop, kind == 1, kind == 0, 1'b1, 1'b0, 1'b0, 2'd0);
    ret = ret + 1'b1;
    idle = !keep;
  endtask

  initial begin
    int r, st;
    logic [5:0] op, fn;
    repeat (2) @(negedge clk);
    #1;
    expect_out(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    instr(6'h00, 6'h20, 0, 1'b1, 1'b0);
    instr(6'h08, 6'h11, 0, 1'b1, 1'b0);
    instr(6'h0C, 6'h05, 0, 1'b1, 1'b0);
    instr(6'h0E, 6'h3F, 0, 1'b0, 1'b0);
    instr(6'h00, 6'h22, 5, 1'b0, 1'b0);
    instr(6'h00, 6'h20, TO, 1'b1, 1'b0);
    instr(6'h00, 6'h24, TO - 1, 1'b1, 1'b0);
    instr(6'h00, 6'h08, 0, 1'b1, 1'b0);
    instr(6'h3F, 6'h00, 0, 1'b1, 1'b0);
    instr(6'h00, 6'h25, 0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) instr(6'h0D, 6'h00, 0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      op = 6'($urandom);
      fn = 6'($urandom);
      if (r < 5) begin op = 6'h00; fn = r_fn[$urandom_range(0, 9)]; end
      else if (r < 7) op = i_oc[$urandom_range(0, 4)];
      else if (r == 7) op = 6'h3F;
      else if (r == 8) op = 6'h00;
      r = $urandom_range(0, 19);
      st = (r < 12) ? 0 : (r < 17) ? $urandom_range(1, 4) : (r == 17) ? TO - 1 : TO;
      instr(op, fn, st, 1'($urandom), $urandom_range(0, 29) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
